// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - programmable NUM_OUT x 2^NUM_IN lookup table swept row by row over valid/ready
module truth_table_sweeper #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 10,
  localparam int FW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int ROWS   = 1 << NUM_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [FW-1:0]      cfg_fn,
  input  logic [NUM_IN-1:0]  cfg_row,
  input  logic               cfg_bit,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [NUM_IN-1:0]  row_idx,
  output logic [NUM_OUT-1:0] row_out,
  output logic               row_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [NUM_IN-1:0] LAST_ROW = {NUM_IN{1'b1}};

  logic [1:0]      state;
  logic [ROWS-1:0] lut [NUM_OUT];

  assign busy      = (state == SWEEP);
  assign row_valid = (state == SWEEP);
  assign done      = (state == DONE);
  assign row_last  = row_valid && (row_idx == LAST_ROW);

  always_comb begin
    row_out = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      row_out[j] = lut[j][row_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SWEEP;
            row_idx <= '0;
          end
        end
        SWEEP: begin
          // The counter stops on the last row, so row_idx never wraps inside a sweep.
          if (row_ready) begin
            if (row_idx == LAST_ROW) begin
              state <= DONE;
            end else begin
              row_idx <= row_idx + NUM_IN'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes land only in IDLE, which freezes the table for the whole sweep;
  // column indices beyond NUM_OUT match no column and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        lut[j] <= '0;
      end
    end else if (state == IDLE && cfg_we) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (cfg_fn == FW'(j)) begin
          lut[j][cfg_row] <= cfg_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;

  localparam int NI = 4;
  localparam int NO = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we, cfg_bit, start, row_ready;
  logic [3:0]    cfg_fn, cfg_row;
  logic          busy, done, row_valid, row_last;
  logic [3:0]    row_idx;
  logic [9:0]    row_out;

  logic          s_cfg_we, s_cfg_bit, s_start, s_row_ready;
  logic [1:0]    s_cfg_fn, s_cfg_row;
  logic          s_busy, s_done, s_row_valid, s_row_last;
  logic [1:0]    s_row_idx;
  logic [2:0]    s_row_out;

  always #5 clk = ~clk;

  truth_table_sweeper #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_fn(cfg_fn), .cfg_row(cfg_row),
    .cfg_bit(cfg_bit), .start(start), .busy(busy), .done(done), .row_valid(row_valid),
    .row_ready(row_ready), .row_idx(row_idx), .row_out(row_out), .row_last(row_last)
  );

  truth_table_sweeper #(.NUM_IN(2), .NUM_OUT(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .cfg_we(s_cfg_we), .cfg_fn(s_cfg_fn), .cfg_row(s_cfg_row),
    .cfg_bit(s_cfg_bit), .start(s_start), .busy(s_busy), .done(s_done), .row_valid(s_row_valid),
    .row_ready(s_row_ready), .row_idx(s_row_idx), .row_out(s_row_out), .row_last(s_row_last)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [9:0] out;
    logic       last;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mdl [NO];
  int          checks = 0;
  int          errors = 0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: compares each presented row against the head of the queue, pops on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      chk("done_pulse", 32'(done), 32'(prev_last));
      if (prev_last) chk("busy_in_done", 32'(busy), 32'd0);
      prev_last = row_valid && row_ready && row_last;
      if (row_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_row actual=%0d expected=none", row_idx);
        end else begin
          mon_e = q[0];
          chk("row_idx", 32'(row_idx), 32'(mon_e.idx));
          chk("row_out", 32'(row_out), 32'(mon_e.out));
          chk("row_last", 32'(row_last), 32'(mon_e.last));
          if (row_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic wr(input int fn, input int r, input logic b);
    cfg_we  = 1'b1;
    cfg_fn  = 4'(fn);
    cfg_row = 4'(r);
    cfg_bit = b;
    @(posedge clk); #1;
    cfg_we  = 1'b0;
    if (fn < NO) mdl[fn][r] = b;
  endtask

  task automatic push_rows();
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.idx  = 4'(r);
      for (int j = 0; j < NO; j++) e.out[j] = mdl[j][r];
      e.last = (r == 15);
      q.push_back(e);
    end
  endtask

  // mode 0 plain, 1 backpressure + frozen-LUT + extra start, 2 reset at row 9, 3 write with start
  task automatic run_sweep(input int mode);
    int   n;
    logic bp_done;
    if (mode == 3) begin
      cfg_we = 1'b1; cfg_fn = 4'd4; cfg_row = 4'd3; cfg_bit = 1'b0;
      mdl[4][3] = 1'b0;
    end
    push_rows();
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    n = 0;
    bp_done = 1'b0;
    while (!done && n < 200) begin
      cfg_we = 1'b0;
      start  = 1'b0;
      if (mode == 1 && row_valid && row_idx == 4'd2) begin
        cfg_we = 1'b1; cfg_fn = 4'd4; cfg_row = 4'd3; cfg_bit = 1'b0;
      end
      if (mode == 1 && row_valid && row_idx == 4'd7) start = 1'b1;
      if (mode == 1 && row_valid && row_idx == 4'd5 && !bp_done) begin
        row_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_hold_idx", 32'(row_idx), 32'd5);
        row_ready = 1'b1;
        bp_done   = 1'b1;
      end
      if (mode == 2 && row_valid && row_idx == 4'd9) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_valid", 32'(row_valid), 32'd0);
        chk("rst_mid_idx", 32'(row_idx), 32'd0);
        chk("rst_mid_out", 32'(row_out), 32'd0);
        chk("rst_mid_last", 32'(row_last), 32'd0);
        q.delete();
        for (int j = 0; j < NO; j++) mdl[j] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) $display("FAIL sweep_timeout actual=%0d expected<200", n);
    chk("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("idle_after_done", 32'({busy, done, row_valid}), 32'd0);
    chk("row_count", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_fn = '0; cfg_row = '0; cfg_bit = 1'b0; start = 1'b0; row_ready = 1'b0;
    s_cfg_we = 1'b0; s_cfg_fn = '0; s_cfg_row = '0; s_cfg_bit = 1'b0; s_start = 1'b0; s_row_ready = 1'b0;
    for (int j = 0; j < NO; j++) mdl[j] = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(row_valid), 32'd0);
    chk("rst_idx", 32'(row_idx), 32'd0);
    chk("rst_out", 32'(row_out), 32'd0);
    chk("rst_last", 32'(row_last), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // function 4 = y.z, function 5 = w'x' + y'z'
    wr(4, 3, 1'b1); wr(4, 7, 1'b1); wr(4, 11, 1'b1); wr(4, 15, 1'b1);
    wr(5, 0, 1'b1); wr(5, 1, 1'b1); wr(5, 2, 1'b1); wr(5, 3, 1'b1);
    wr(5, 4, 1'b1); wr(5, 8, 1'b1); wr(5, 12, 1'b1);
    wr(12, 0, 1'b1);
    chk("mdl_fn4", 32'(mdl[4]), 32'h8888);
    chk("mdl_fn5", 32'(mdl[5]), 32'h111F);
    row_ready = 1'b1;

    run_sweep(0);
    run_sweep(1);
    run_sweep(3);
    run_sweep(2);
    run_sweep(0);

    s_cfg_we = 1'b1; s_cfg_fn = 2'd3; s_cfg_row = 2'd1; s_cfg_bit = 1'b1;
    @(posedge clk); #1;
    s_cfg_fn = 2'd2; s_cfg_row = 2'd2;
    @(posedge clk); #1;
    s_cfg_we = 1'b0; s_row_ready = 1'b1; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk("s_valid", 32'(s_row_valid), 32'd1);
      chk("s_idx", 32'(s_row_idx), 32'(r));
      chk("s_out", 32'(s_row_out), (r == 2) ? 32'd4 : 32'd0);
      chk("s_last", 32'(s_row_last), 32'(r == 3));
      @(posedge clk); #1;
    end
    chk("s_done", 32'(s_done), 32'd1);
    chk("s_busy_done", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    chk("s_done_clear", 32'(s_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, sequential successor to our fixed 4-input/10-output combinational breadboard function block. Each of NUM_OUT output functions of NUM_IN inputs is held in a programmable lookup table loaded one minterm at a time. On `start` the block sweeps every input combination from 0 to 2^NUM_IN−1 and emits one truth-table row per valid/ready transfer. It sits between the configuration source and the truth-table display/checker logic.

## Interface
- NUM_IN, 4, number of function inputs; rows per sweep = 2^NUM_IN; legal range 1..8
- NUM_OUT, 10, number of output functions (LUT columns); legal range 1..32
- FW = clog2(NUM_OUT), minimum 1; derived, not overridable

- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  LUT write strobe
- cfg_fn  in  FW  function (column) index to write
- cfg_row  in  NUM_IN  minterm (row) index to write
- cfg_bit  in  1  value stored at lut[cfg_fn][cfg_row]
- start  in  1  begin a sweep; honoured only in IDLE
- busy  out  1  high in SWEEP
- done  out  1  one-cycle pulse after the last row transfers
- row_valid  out  1  row_idx/row_out/row_last valid
- row_ready  in  1  consumer accepts the row
- row_idx  out  NUM_IN  current input combination; MSB = first input (w)
- row_out  out  NUM_OUT  row_out[j] = lut[j][row_idx]
- row_last  out  1  high when row_valid and row_idx = 2^NUM_IN−1

## Operation
- Storage: NUM_OUT × 2^NUM_IN bits. Reset clears every bit to 0.
- Write: when cfg_we=1 in IDLE, lut[cfg_fn][cfg_row] ← cfg_bit at the edge. A write with cfg_fn ≥ NUM_OUT is dropped. cfg_we is ignored in SWEEP and DONE, so the LUT is frozen during a sweep.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP on start=1. row_idx ← 0.
  - SWEEP: row_valid=1. A transfer occurs on an edge where row_valid & row_ready.
    - Transfer with row_idx < 2^NUM_IN−1: row_idx increments, state stays SWEEP.
    - Transfer with row_idx = 2^NUM_IN−1: state → DONE.
  - DONE: done=1, row_valid=0, busy=0. Next edge goes unconditionally to IDLE.
- start is ignored in SWEEP and DONE. There is no abort; only rst_n terminates a sweep.
- If start and cfg_we are both high in IDLE on the same edge, the write commits and the sweep begins. The written bit is visible in the sweep.
- row_out and row_last are combinational from the registered row_idx and the frozen LUT. They are stable while row_valid=1 and row_ready=0.
- row_idx is NUM_IN wide. It never wraps within a sweep because the counter stops at the last row.
- In IDLE and DONE, row_idx holds its last value. row_out follows the LUT but carries no meaning, since row_valid=0.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state=IDLE, busy=0, done=0, row_valid=0, row_idx=0, row_last=0, LUT all 0. row_out therefore reads 0.
- Reset mid-sweep takes effect immediately, without waiting for a clock. After release the block is in IDLE and requires a new start.
- start sampled at edge k: busy=1, row_valid=1, row_idx=0 from k+1.
- With row_ready held high, one row transfers per cycle. A full sweep occupies 2^NUM_IN cycles of row_valid.
- Last transfer at edge m: done=1 and busy=0 during cycle m+1. Back in IDLE at m+2. The earliest accepted new start is the edge ending cycle m+2 (the m+2→m+3 edge).
- row_ready low: row_idx and row_out hold for as many cycles as it stays low. No row is skipped or repeated.
- A LUT write takes effect for a row read in the cycle after the write edge.

## Test plan
- Reset: assert rst_n=0 mid-cycle with clk idle → busy, done, row_valid, row_idx, row_out all 0 at once. Read-back sweep after release shows all row_out=0.
- Program function 4 as y·z (rows 3, 7, 11, 15 = 1) and function 5 as w'x'+y'z' (rows 0–4, 8, 12 = 1). Start with row_ready=1 → 16 consecutive rows. row_out[4]=1 exactly at rows 3, 7, 11, 15; row_out[5] matches its programmed rows. row_last=1 only at row 15. done pulses 1 cycle later.
- Backpressure: drop row_ready for 3 cycles while row_idx=5 → row_idx=5 and row_out held for 4 cycles, then row 6 follows. The total row count is still 16.
- cfg_we to lut[4][3] ← 0 during the sweep → ignored; row 3 still shows row_out[4]=1. The same write in IDLE → next sweep shows 0. A second start pulse mid-sweep has no effect.
- Assert rst_n=0 at row 9 → outputs 0 immediately and LUT cleared. A new start after release sweeps from row 0.
- Instance with NUM_IN=2, NUM_OUT=3 → 4 rows per sweep, done after row 3. A write with cfg_fn=3 is dropped.
